isqrt_pipe: RTL and testbench

- Fully pipelined unsigned integer square root: y = floor(sqrt(x)) for 32-bit x, 16-bit y.
- Sits directly downstream of the formula FSMs (formula_1_pipe_aware_fsm and siblings), instantiated beside them in the *_top wrappers.
- Accepts one argument per clock with no backpressure.
- Latency is fixed at N_STAGES cycles so the upstream FSM can schedule issue and collect deterministically.

---
 rtl/isqrt_pkg.sv | 40 ++++
 rtl/isqrt_pipe_stage.sv | 49 ++++
 rtl/isqrt_pipe.sv | 65 ++++++
 tb/tb_isqrt_pipe.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared widths, the per-iteration pipeline payload and the
// single-iteration step of the digit-by-digit integer square root.
//
// isqrt_iter consumes the two most significant unconsumed radicand bits.
// It produces one root bit and keeps the remainder within ISQRT_R_W bits.
package isqrt_pkg;

  localparam int ISQRT_X_W = 32;
  localparam int ISQRT_Y_W = 16;
  localparam int ISQRT_R_W = 18;

  typedef struct packed {
    logic [ISQRT_R_W-1:0] r;     // running remainder
    logic [ISQRT_Y_W-1:0] q;     // partial root
    logic [ISQRT_X_W-1:0] xrem;  // unconsumed radicand bits, MSB-aligned
  } isqrt_stage_t;

  // One restoring iteration.
  // The remainder never exceeds 2*q, so (r<<2)|pair fits in 18 bits.
  // Likewise (q<<2)|1 fits, because q has at most 15 significant bits
  // before the last iteration.
  // The casts therefore only drop bits that are provably zero.
  function automatic isqrt_stage_t isqrt_iter(input isqrt_stage_t s);
    isqrt_stage_t         o;
    logic [ISQRT_R_W-1:0] r_sh;
    logic [ISQRT_R_W-1:0] t;
    r_sh   = ISQRT_R_W'({s.r, s.xrem[ISQRT_X_W-1 -: 2]});
    t      = {s.q, 2'b01};
    o.xrem = {s.xrem[ISQRT_X_W-3:0], 2'b00};
    if (r_sh >= t) begin
      o.r = r_sh - t;
      o.q = ISQRT_Y_W'({s.q, 1'b1});
    end else begin
      o.r = r_sh;
      o.q = ISQRT_Y_W'({s.q, 1'b0});
    end
    return o;
  endfunction

endpackage

// File: rtl/isqrt_pipe_stage.sv
// isqrt_pipe_stage: ITER chained square-root iterations followed by one
// register stage.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   i_vld     previous stage valid
//   i_data    previous stage payload (r, q, xrem)
//   o_vld     registered valid; always advances
//   o_data    registered payload; loads only when i_vld=1, otherwise holds
module isqrt_pipe_stage
  import isqrt_pkg::*;
#(
  parameter int ITER = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  input  isqrt_stage_t i_data,
  output logic         o_vld,
  output isqrt_stage_t o_data
);

  isqrt_stage_t w_chain [0:ITER];
  isqrt_stage_t r_data;
  logic         r_vld;

  assign w_chain[0] = i_data;

  for (genvar i = 0; i < ITER; i++) begin : g_iter
    assign w_chain[i+1] = isqrt_iter(w_chain[i]);
  end

  // The valid bit advances every cycle so that gaps in the input
  // reproduce exactly at the output.
  // Data holds through bubbles, so the output keeps the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) r_data <= w_chain[ITER];
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fully pipelined y = floor(sqrt(x)) with a 32-bit argument
// and a 16-bit result, accepting one argument per cycle.
//
// Handshake: valid-only, no ready.
//   - x is taken on every rising edge where x_vld=1.
//   - y_vld pulses for one cycle exactly N_STAGES cycles later.
//   - The consumer must take y on that pulse.
//
// Ports:
//   clk    clock, all state on the rising edge
//   rst    synchronous active-high reset; drops all in-flight arguments
//   x_vld  argument valid
//   x      unsigned radicand
//   y_vld  result valid, one pulse per accepted argument
//   y      floor(sqrt(x)); holds the last result while y_vld=0
module isqrt_pipe
  import isqrt_pkg::*;
#(
  parameter int N_STAGES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_vld,
  input  logic [ISQRT_X_W-1:0] x,
  output logic                 y_vld,
  output logic [ISQRT_Y_W-1:0] y
);

  localparam int ITER_PER_STAGE = ISQRT_Y_W / N_STAGES;

  if (!(N_STAGES == 1 || N_STAGES == 2 || N_STAGES == 4 ||
        N_STAGES == 8 || N_STAGES == 16)) begin : g_bad_n_stages
    $error("isqrt_pipe: N_STAGES must be 1, 2, 4, 8 or 16");
  end

  isqrt_stage_t             w_stage [0:N_STAGES];
  logic [N_STAGES:0]        w_vld;

  // Stage 0: the raw argument with an empty remainder and root.
  assign w_vld[0]        = x_vld;
  assign w_stage[0].r    = '0;
  assign w_stage[0].q    = '0;
  assign w_stage[0].xrem = x;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    isqrt_pipe_stage #(
      .ITER (ITER_PER_STAGE)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_vld  (w_vld[k]),
      .i_data (w_stage[k]),
      .o_vld  (w_vld[k+1]),
      .o_data (w_stage[k+1])
    );
  end

  assign y_vld = w_vld[N_STAGES];
  assign y     = w_stage[N_STAGES].q;

  // After the last iteration, r is discarded and xrem is always zero.
  logic w_unused_tail;
  assign w_unused_tail = ^{w_stage[N_STAGES].r, w_stage[N_STAGES].xrem};

endmodule

// File: tb/tb_isqrt_pipe.sv
// Bench for isqrt_pipe.
//
// The driver pushes each expected root and its arrival cycle into a
// queue. The monitor pops and compares on every y_vld.
module tb_isqrt_pipe;

  localparam int N_STAGES = 16;

  logic        clk;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rst_at_edge = 1'b1;
  logic [15:0] last_y = '0;

  logic [15:0] exp_q [$];
  int          cyc_q [$];

  isqrt_pipe #(.N_STAGES(N_STAGES)) dut (
    .clk   (clk),
    .rst   (rst),
    .x_vld (x_vld),
    .x     (x),
    .y_vld (y_vld),
    .y     (y)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge  = rst;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: greedy bit-by-bit search on 64-bit squares.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    logic [15:0] res;
    logic [15:0] cand;
    res = '0;
    for (int b = 15; b >= 0; b--) begin
      cand = res | (16'd1 << b);
      if (64'(cand) * 64'(cand) <= 64'(v)) res = cand;
    end
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] xv, input logic [15:0] yv);
    @(posedge clk);
    #1;
    x_vld = 1'b1;
    x     = xv;
    exp_q.push_back(yv);
    cyc_q.push_back(cyc + N_STAGES);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      x_vld = 1'b0;
      x     = $urandom;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (y_vld) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_y_vld: got y=%0h with no pending argument (cycle %0d)", y, cyc);
      end else begin
        check("y_value", {16'd0, y}, {16'd0, exp_q.pop_front()});
        check("y_latency", cyc, cyc_q.pop_front());
      end
    end else if (!rst && !rst_at_edge) begin
      check("y_hold", {16'd0, y}, {16'd0, last_y});
    end
    last_y = y;
  end

  // ---------------- directed vectors ----------------
  logic [31:0] dir_x [0:18] = '{
    32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd15, 32'd16, 32'd24, 32'd25,
    32'd143, 32'd144, 32'd65535, 32'd65536, 32'd1000000,
    32'hFFFE0000, 32'hFFFE0001, 32'hFFFFFFFF, 32'h40000000, 32'h3FFFFFFF
  };
  logic [15:0] dir_y [0:18] = '{
    16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd5,
    16'd11, 16'd12, 16'd255, 16'd256, 16'd1000,
    16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF
  };
  logic [31:0] iso_x [0:4] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFFFFFF};
  logic [15:0] iso_y [0:4] = '{16'd0, 16'd1, 16'd3, 16'd4, 16'hFFFF};

  initial begin
    logic [31:0] rx;
    rst   = 1'b1;
    x_vld = 1'b0;
    x     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_y_vld", {31'd0, y_vld}, 32'd0);
    check("reset_y", {16'd0, y}, 32'd0);

    // Isolated arguments with idle gaps.
    for (int i = 0; i < 5; i++) begin
      issue(iso_x[i], iso_y[i]);
      idle(N_STAGES + 3);
    end

    // Back-to-back stream: directed table then reference-checked randoms.
    for (int i = 0; i < 200; i++) begin
      if (i < 19) issue(dir_x[i], dir_y[i]);
      else begin
        rx = $urandom;
        issue(rx, ref_sqrt(rx));
      end
    end
    idle(N_STAGES + 2);

    // Random ~50% valid pattern.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      rx = (i % 2 == 0) ? $urandom : $urandom_range(0, 70000);
      issue(rx, ref_sqrt(rx));
    end
    idle(N_STAGES + 2);

    // Reset with arguments in flight; x_vld during reset is ignored.
    for (int i = 0; i < 5; i++) issue(32'd100 + i, ref_sqrt(32'd100 + i));
    @(posedge clk);
    #1;
    rst   = 1'b1;
    x_vld = 1'b1;
    x     = 32'd99;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    x_vld = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    idle(N_STAGES + 4);

    issue(32'd144, 16'd12);
    idle(2);

    // Bounded drain.
    for (int i = 0; i < N_STAGES + 8 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_pending", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
